// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb memory arbiter: reset address, FSM and
// master-id encodings, latched transaction record and byte-mask expansion.
package mem_arb_pkg;

  localparam logic [63:0] PC_START_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    MST_IF = 1'b0,
    MST_LS = 1'b1
  } master_e;

  typedef struct packed {
    master_e     master;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;

  // One store-mask bit covers a whole byte lane of the RAM bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] byte_mask);
    logic [63:0] bit_mask;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
    end
    return bit_mask;
  endfunction

endpackage

// File: rtl/mem_arb_addr_map.sv
// Byte address to RAM word index translation with range check (combinational).
module mem_arb_addr_map
  import mem_arb_pkg::*;
#(
  parameter logic [63:0] PC_START = PC_START_DEFAULT,
  parameter int          IDX_W    = 16
) (
  input  logic [63:0]      addr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             in_range_o
);

  logic [63:0] word;

  // Addresses below PC_START wrap to a huge word number, but are rejected
  // by the explicit lower-bound compare anyway.
  assign word       = (addr_i - PC_START) >> 3;
  assign idx_o      = word[IDX_W-1:0];
  assign in_range_o = (addr_i >= PC_START) && ((word >> IDX_W) == 64'd0);

endmodule

// File: rtl/mem_arb.sv
// Two-master (fetch / load-store) arbiter onto a single-port RAM, one access
// in flight. Define MEM_ARB_RR_EN for round-robin; default is LS-over-IF.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [63:0] PC_START = PC_START_DEFAULT,
  parameter int          IDX_W    = 16
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             if_req_i,
  input  logic [63:0]      if_addr_i,
  output logic             if_ready_o,
  output logic [63:0]      if_rdata_o,

  input  logic             ls_req_i,
  input  logic             ls_wen_i,
  input  logic [63:0]      ls_addr_i,
  input  logic [63:0]      ls_wdata_i,
  input  logic [7:0]       ls_wmask_i,
  output logic             ls_ready_o,
  output logic [63:0]      ls_rdata_o,

  output logic             ram_en_o,
  output logic             ram_wen_o,
  output logic [IDX_W-1:0] ram_idx_o,
  output logic [63:0]      ram_wdata_o,
  output logic [63:0]      ram_wmask_o,
  input  logic [63:0]      ram_rdata_i
);

  state_e           state_q, state_d;
  txn_t             txn_q, txn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_range_q, in_range_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_wen_q, ram_wen_d;
  logic             if_ready_q, if_ready_d;
  logic             ls_ready_q, ls_ready_d;
  logic [63:0]      if_rdata_q, if_rdata_d;
  logic [63:0]      ls_rdata_q, ls_rdata_d;
`ifdef MEM_ARB_RR_EN
  master_e          last_q, last_d;
`endif

  master_e          grant;
  logic [63:0]      grant_addr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_in_range;
  logic [63:0]      resp_data;

  always_comb begin
    grant = MST_IF;
`ifdef MEM_ARB_RR_EN
    if (ls_req_i && if_req_i) begin
      grant = (last_q == MST_LS) ? MST_IF : MST_LS;
    end else if (ls_req_i) begin
      grant = MST_LS;
    end
`else
    if (ls_req_i) begin
      grant = MST_LS;
    end
`endif
  end

  assign grant_addr = (grant == MST_LS) ? ls_addr_i : if_addr_i;

  mem_arb_addr_map #(
    .PC_START (PC_START),
    .IDX_W    (IDX_W)
  ) u_addr_map (
    .addr_i     (grant_addr),
    .idx_o      (grant_idx),
    .in_range_o (grant_in_range)
  );

  assign resp_data = in_range_q ? ram_rdata_i : 64'd0;

  always_comb begin
    // NOTE: every _d takes its hold/idle value first, so no branch can leave
    // one unassigned and infer a latch.
    state_d    = state_q;
    txn_d      = txn_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    ram_en_d   = 1'b0;
    ram_wen_d  = 1'b0;
    if_ready_d = 1'b0;
    ls_ready_d = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d      = ST_ACCESS;
          txn_d.master = grant;
          txn_d.wen    = (grant == MST_LS) && ls_wen_i;
          txn_d.wdata  = (grant == MST_LS) ? ls_wdata_i : 64'd0;
          txn_d.wmask  = (grant == MST_LS) ? ls_wmask_i : 8'd0;
          idx_d        = grant_idx;
          in_range_d   = grant_in_range;
          ram_en_d     = grant_in_range;
          ram_wen_d    = grant_in_range && (grant == MST_LS) && ls_wen_i;
`ifdef MEM_ARB_RR_EN
          last_d       = grant;
`endif
        end
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        if_ready_d = (txn_q.master == MST_IF);
        ls_ready_d = (txn_q.master == MST_LS);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!txn_q.wen) begin
          if (txn_q.master == MST_IF) begin
            if_rdata_d = resp_data;
          end else begin
            ls_rdata_d = resp_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      txn_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_wen_q  <= 1'b0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_rdata_q <= 64'd0;
      ls_rdata_q <= 64'd0;
`ifdef MEM_ARB_RR_EN
      last_q     <= MST_IF;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values.
      state_q    <= state_d;
      txn_q      <= txn_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      ram_en_q   <= ram_en_d;
      ram_wen_q  <= ram_wen_d;
      if_ready_q <= if_ready_d;
      ls_ready_q <= ls_ready_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  // Reset is synchronous, so the enables are gated directly to stop a write
  // committing on the very edge that reset takes effect.
  assign ram_en_o    = ram_en_q & ~reset;
  assign ram_wen_o   = ram_wen_q & ~reset;
  assign ram_idx_o   = idx_q;
  assign ram_wdata_o = txn_q.wdata;
  assign ram_wmask_o = expand_mask(txn_q.wmask);

  assign if_ready_o  = if_ready_q;
  assign ls_ready_o  = ls_ready_q;
  // Read data is forwarded during the response cycle and held afterwards.
  assign if_rdata_o  = if_rdata_d;
  assign ls_rdata_o  = ls_rdata_d;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// transactions against a byte-level reference memory model.
module tb_mem_arb;

  localparam logic [63:0] PC    = 64'h8000_0000;
  localparam int          IDX_W = 16;
  localparam int          DEPTH = 1 << IDX_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             if_req_i = 1'b0;
  logic [63:0]      if_addr_i = '0;
  logic             if_ready_o;
  logic [63:0]      if_rdata_o;
  logic             ls_req_i = 1'b0;
  logic             ls_wen_i = 1'b0;
  logic [63:0]      ls_addr_i = '0;
  logic [63:0]      ls_wdata_i = '0;
  logic [7:0]       ls_wmask_i = '0;
  logic             ls_ready_o;
  logic [63:0]      ls_rdata_o;
  logic             ram_en_o;
  logic             ram_wen_o;
  logic [IDX_W-1:0] ram_idx_o;
  logic [63:0]      ram_wdata_o;
  logic [63:0]      ram_wmask_o;
  logic [63:0]      ram_rdata_i = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_arb #(.PC_START(PC), .IDX_W(IDX_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ready_o  (if_ready_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req_i),
    .ls_wen_i    (ls_wen_i),
    .ls_addr_i   (ls_addr_i),
    .ls_wdata_i  (ls_wdata_i),
    .ls_wmask_i  (ls_wmask_i),
    .ls_ready_o  (ls_ready_o),
    .ls_rdata_o  (ls_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_wen_o   (ram_wen_o),
    .ram_idx_o   (ram_idx_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wmask_o (ram_wmask_o),
    .ram_rdata_i (ram_rdata_i)
  );

  function automatic logic [63:0] init_word(input longint i);
    return 64'hC0DE_0000_0000_0000 + i * 64'h1_0000_0101;
  endfunction

  // RAM attached to the DUT: one-cycle read latency, bit-masked writes.
  logic [63:0] ram_mem [0:DEPTH-1];
  bit          ram_wr  [0:DEPTH-1];

  function automatic logic [63:0] env_peek(input int i);
    return ram_wr[i] ? ram_mem[i] : init_word(longint'(i));
  endfunction

  always @(posedge clock) begin
    if (ram_en_o) begin
      if (ram_wen_o) begin
        ram_mem[ram_idx_o] <= (env_peek(int'(ram_idx_o)) & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
        ram_wr[ram_idx_o]  <= 1'b1;
      end
      ram_rdata_i <= env_peek(int'(ram_idx_o));
    end
  end

  // Reference model: memory contents as seen through byte addresses.
  logic [63:0] ref_mem [longint];
  logic [63:0] exp_if_rdata = '0;
  logic [63:0] exp_ls_rdata = '0;

  function automatic bit ref_in_range(input logic [63:0] a);
    return (a >= PC) && ((a - PC) / 8 < 64'(DEPTH));
  endfunction

  function automatic longint ref_index(input logic [63:0] a);
    return longint'((a - PC) / 8);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    longint i;
    if (!ref_in_range(a)) return 64'd0;
    i = ref_index(a);
    return ref_mem.exists(i) ? ref_mem[i] : init_word(i);
  endfunction

  function automatic void ref_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    if (!ref_in_range(a)) return;
    w = ref_read(a);
    for (int b = 0; b < 8; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[ref_index(a)] = w;
  endfunction

  function automatic logic [63:0] lanes(input logic [7:0] m);
    logic [63:0] r = 64'd0;
    for (int b = 0; b < 8; b++) if (m[b]) r = r | (64'hFF << (8 * b));
    return r;
  endfunction

  // Drives one request from IDLE and records what the DUT did with it;
  // returns one cycle after the response, back in IDLE.
  task automatic run_txn(input bit is_ls, input bit wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         output int lat, output int en_cnt, output bit wen_seen,
                         output bit wrong_ready, output logic [IDX_W-1:0] acc_idx,
                         output logic [63:0] acc_wdata, output logic [63:0] acc_wmask,
                         output logic [63:0] rdata, output logic [63:0] rdata_after);
    lat = -1; en_cnt = 0; wen_seen = 0; wrong_ready = 0;
    acc_idx = '0; acc_wdata = '0; acc_wmask = '0; rdata = '0;
    if (is_ls) begin
      ls_req_i = 1'b1; ls_wen_i = wen; ls_addr_i = addr; ls_wdata_i = wdata; ls_wmask_i = wmask;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clock); #1;
      if (ram_en_o) begin
        en_cnt++; acc_idx = ram_idx_o; acc_wdata = ram_wdata_o; acc_wmask = ram_wmask_o;
      end
      if (ram_wen_o) wen_seen = 1;
      if (is_ls ? if_ready_o : ls_ready_o) wrong_ready = 1;
      if (is_ls ? ls_ready_o : if_ready_o) begin
        lat = c; rdata = is_ls ? ls_rdata_o : if_rdata_o;
      end
    end
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_wen_i = 1'b0;
    @(posedge clock); #1;
    rdata_after = is_ls ? ls_rdata_o : if_rdata_o;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req_i = 1'b0; ls_req_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ls_req_i = 1'b1; if_req_i = 1'b1; ls_addr_i = PC; if_addr_i = PC;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (ram_en_o !== 1'b0) begin miscompares++; $display("FAIL reset_ram_en: got %b want 0", ram_en_o); end
    vectors++; if (ram_wen_o !== 1'b0) begin miscompares++; $display("FAIL reset_ram_wen: got %b want 0", ram_wen_o); end
    vectors++; if ({if_ready_o, ls_ready_o} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", {if_ready_o, ls_ready_o}); end
    vectors++; if (if_rdata_o !== 64'd0) begin miscompares++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata_o); end
    vectors++; if (ls_rdata_o !== 64'd0) begin miscompares++; $display("FAIL reset_ls_rdata: got %h want 0", ls_rdata_o); end
    reset = 1'b0; ls_req_i = 1'b0; if_req_i = 1'b0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
  endtask

  task automatic test_if_read();
    int lat, en; bit ws, wr; logic [IDX_W-1:0] ai; logic [63:0] ad, am, rd, ra;
    logic [63:0] addrs [2];
    logic [IDX_W-1:0] idxs [2];
    addrs[0] = 64'h8000_0010;                   idxs[0] = 16'd2;
    addrs[1] = PC + 64'(DEPTH - 1) * 8 + 64'd7; idxs[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b0, 1'b0, addrs[k], '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
      exp_if_rdata = ref_read(addrs[k]);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL if_read_latency[%0d]: got %0d want 2", k, lat); end
      vectors++; if (en !== 1 || ai !== idxs[k]) begin miscompares++; $display("FAIL if_read_idx[%0d]: en %0d idx %h want en 1 idx %h", k, en, ai, idxs[k]); end
      vectors++; if (ws !== 1'b0 || wr !== 1'b0) begin miscompares++; $display("FAIL if_read_wen_or_ls_ready[%0d]: wen %b ls_ready %b want 0 0", k, ws, wr); end
      vectors++; if (rd !== exp_if_rdata || ra !== exp_if_rdata) begin miscompares++; $display("FAIL if_read_rdata[%0d]: got %h then %h want %h", k, rd, ra, exp_if_rdata); end
    end
  endtask

  task automatic test_ls_store();
    int lat, en; bit ws, wr; logic [IDX_W-1:0] ai; logic [63:0] ad, am, rd, ra;
    run_txn(1'b1, 1'b0, PC + 64'd24, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_ls_rdata = ref_read(PC + 64'd24);
    vectors++; if (rd !== exp_ls_rdata) begin miscompares++; $display("FAIL ls_load_rdata: got %h want %h", rd, exp_ls_rdata); end
    run_txn(1'b1, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F, lat, en, ws, wr, ai, ad, am, rd, ra);
    ref_write(64'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F);
    vectors++; if (am !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL store_wmask: got %h want 00000000ffffffff", am); end
    vectors++; if (ws !== 1'b1 || en !== 1 || ai !== 16'd1) begin miscompares++; $display("FAIL store_access: wen %b en %0d idx %h want 1 1 0001", ws, en, ai); end
    vectors++; if (ad !== 64'h1122_3344_5566_7788) begin miscompares++; $display("FAIL store_wdata: got %h want 1122334455667788", ad); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL store_latency: got %0d want 2", lat); end
    vectors++; if (rd !== exp_ls_rdata || ra !== exp_ls_rdata) begin miscompares++; $display("FAIL store_keeps_ls_rdata: got %h then %h want %h", rd, ra, exp_ls_rdata); end
    run_txn(1'b0, 1'b0, 64'h8000_0008, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_if_rdata = ref_read(64'h8000_0008);
    vectors++; if (rd !== exp_if_rdata) begin miscompares++; $display("FAIL store_readback: got %h want %h", rd, exp_if_rdata); end
  endtask

  task automatic test_out_of_range();
    int lat, en; bit ws, wr; logic [IDX_W-1:0] ai; logic [63:0] ad, am, rd, ra;
    run_txn(1'b1, 1'b0, 64'h7FFF_FFF8, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_ls_rdata = 64'd0;
    vectors++; if (en !== 0) begin miscompares++; $display("FAIL oor_low_ram_en: got %0d enables want 0", en); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL oor_low_latency: got %0d want 2", lat); end
    vectors++; if (rd !== 64'd0 || ra !== 64'd0) begin miscompares++; $display("FAIL oor_low_rdata: got %h then %h want 0", rd, ra); end
    run_txn(1'b1, 1'b1, PC + 64'(DEPTH) * 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, en, ws, wr, ai, ad, am, rd, ra);
    vectors++; if (en !== 0 || ws !== 1'b0 || lat !== 2) begin miscompares++; $display("FAIL oor_high_store: en %0d wen %b lat %0d want 0 0 2", en, ws, lat); end
    run_txn(1'b0, 1'b0, PC + 64'(DEPTH) * 8, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_if_rdata = 64'd0;
    vectors++; if (en !== 0 || rd !== 64'd0) begin miscompares++; $display("FAIL oor_high_fetch: en %0d rdata %h want 0 0", en, rd); end
    run_txn(1'b0, 1'b0, PC, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_if_rdata = ref_read(PC);
    vectors++; if (rd !== exp_if_rdata) begin miscompares++; $display("FAIL oor_no_alias_write: got %h want %h", rd, exp_if_rdata); end
  endtask

  task automatic test_arbitration();
    bit exp_ls [4];
    bit got_ls;
    int waited;
    logic [63:0] if_a, ls_a, got, want;
    do_reset();
    if_a = PC + 64'd80; ls_a = PC + 64'd160;
`ifdef MEM_ARB_RR_EN
    exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    if_req_i = 1'b1; if_addr_i = if_a;
    ls_req_i = 1'b1; ls_wen_i = 1'b0; ls_addr_i = ls_a;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        @(posedge clock); #1; waited++;
      end while (!if_ready_o && !ls_ready_o && waited < 8);
      got_ls = ls_ready_o;
      vectors++;
      if (!(if_ready_o ^ ls_ready_o) || got_ls !== exp_ls[k]) begin
        miscompares++; $display("FAIL arb_grant[%0d]: if_ready %b ls_ready %b want ls=%b", k, if_ready_o, ls_ready_o, exp_ls[k]);
      end
      vectors++;
      if (waited !== ((k == 0) ? 2 : 3)) begin
        miscompares++; $display("FAIL arb_spacing[%0d]: got %0d cycles want %0d", k, waited, (k == 0) ? 2 : 3);
      end
      got  = got_ls ? ls_rdata_o : if_rdata_o;
      want = ref_read(got_ls ? ls_a : if_a);
      if (got_ls) exp_ls_rdata = want; else exp_if_rdata = want;
      vectors++; if (got !== want) begin miscompares++; $display("FAIL arb_rdata[%0d]: got %h want %h", k, got, want); end
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_in_access();
    int lat, en; bit ws, wr; logic [IDX_W-1:0] ai; logic [63:0] ad, am, rd, ra;
    logic [63:0] a;
    a = PC + 64'd40;
    ls_req_i = 1'b1; ls_wen_i = 1'b1; ls_addr_i = a; ls_wdata_i = 64'hDEAD_BEEF_DEAD_BEEF; ls_wmask_i = 8'hFF;
    @(posedge clock); #1;
    vectors++; if (ram_en_o !== 1'b1) begin miscompares++; $display("FAIL rst_acc_pre_en: got %b want 1", ram_en_o); end
    reset = 1'b1; ls_req_i = 1'b0; ls_wen_i = 1'b0;
    #1;
    vectors++; if (ram_en_o !== 1'b0 || ram_wen_o !== 1'b0) begin miscompares++; $display("FAIL rst_acc_gate: en %b wen %b want 0 0", ram_en_o, ram_wen_o); end
    @(posedge clock); #1;
    reset = 1'b0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
    vectors++; if (ls_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_acc_ready0: got %b want 0", ls_ready_o); end
    @(posedge clock); #1;
    vectors++; if (ls_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_acc_ready1: got %b want 0", ls_ready_o); end
    vectors++; if (env_peek(5) !== ref_read(a)) begin miscompares++; $display("FAIL rst_acc_ram_word: got %h want %h", env_peek(5), ref_read(a)); end
    run_txn(1'b0, 1'b0, a, '0, '0, lat, en, ws, wr, ai, ad, am, rd, ra);
    exp_if_rdata = ref_read(a);
    vectors++; if (lat !== 2 || rd !== exp_if_rdata) begin miscompares++; $display("FAIL rst_acc_after: lat %0d rdata %h want 2 %h", lat, rd, exp_if_rdata); end
  endtask

  task automatic test_random();
    int lat, en; bit ws, wr; logic [IDX_W-1:0] ai; logic [63:0] ad, am, rd, ra;
    bit is_ls, wen, inr;
    int r;
    logic [63:0] a, d, want;
    logic [7:0] m;
    for (int n = 0; n < 150; n++) begin
      is_ls = 1'($urandom_range(0, 1));
      wen   = is_ls && ($urandom_range(0, 2) == 0);
      r     = int'($urandom_range(0, 9));
      if (r == 0)      a = PC - 64'(8 * $urandom_range(1, 1000));
      else if (r == 1) a = PC + 64'(DEPTH) * 8 + 64'(8 * $urandom_range(0, 1000));
      else if (r == 2) a = PC + 64'(DEPTH - 1 - int'($urandom_range(0, 3))) * 8;
      else             a = PC + 64'(8 * $urandom_range(0, 63)) + 64'($urandom_range(0, 7));
      d   = {$urandom, $urandom};
      m   = 8'($urandom_range(0, 255));
      inr = ref_in_range(a);
      run_txn(is_ls, wen, a, d, m, lat, en, ws, wr, ai, ad, am, rd, ra);
      if (wen) begin
        want = exp_ls_rdata;
        ref_write(a, d, m);
      end else begin
        want = ref_read(a);
        if (is_ls) exp_ls_rdata = want; else exp_if_rdata = want;
      end
      vectors++; if (lat !== 2 || wr !== 1'b0) begin miscompares++; $display("FAIL rnd_handshake[%0d]: lat %0d wrong_ready %b", n, lat, wr); end
      vectors++; if (en !== (inr ? 1 : 0) || ws !== (inr && wen)) begin miscompares++; $display("FAIL rnd_enables[%0d]: addr %h en %0d wen %b", n, a, en, ws); end
      if (inr) begin
        vectors++; if (ai !== 16'(ref_index(a))) begin miscompares++; $display("FAIL rnd_idx[%0d]: got %h want %h", n, ai, 16'(ref_index(a))); end
      end
      if (inr && wen) begin
        vectors++; if (am !== lanes(m) || ad !== d) begin miscompares++; $display("FAIL rnd_store_bus[%0d]: mask %h data %h want %h %h", n, am, ad, lanes(m), d); end
      end
      vectors++; if (rd !== want || ra !== want) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h then %h want %h", n, rd, ra, want); end
      vectors++;
      if ((is_ls ? if_rdata_o : ls_rdata_o) !== (is_ls ? exp_if_rdata : exp_ls_rdata)) begin
        miscompares++; $display("FAIL rnd_other_rdata[%0d]: got %h want %h", n, is_ls ? if_rdata_o : ls_rdata_o, is_ls ? exp_if_rdata : exp_ls_rdata);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_if_read();
    test_ls_store();
    test_out_of_range();
    test_arbitration();
    test_reset_in_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
